// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings for the memory slave: burst types and response codes.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Combinational AXI4 next-beat address: FIXED holds, INCR steps by 1<<size,
// WRAP steps within an aligned (len+1)<<size window; reserved bursts behave as INCR.
module axi_mem_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WD = 32
) (
    input  logic [ADDR_WD-1:0] addr,
    input  logic [2:0]         size,
    input  logic [7:0]         len,
    input  logic [1:0]         burst,
    output logic [ADDR_WD-1:0] next_addr
);

    logic [ADDR_WD-1:0] step;
    logic [ADDR_WD-1:0] incr_addr;
    logic [ADDR_WD-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WD'(1) << size;
        incr_addr = addr + step;
        // Window size minus one; low bits step, high bits stay at the aligned base.
        wrap_mask = ((ADDR_WD'(len) + ADDR_WD'(1)) << size) - ADDR_WD'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave scratch memory with independent single-outstanding read and write bursts.
// Optional AXI_MEM_OOR_SLVERR_EN: out-of-range beats read 0 / skip the write and return SLVERR.
module axi_mem_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXI_ARVALID,
    input  logic [ADDR_WD-1:0]   S_AXI_ARADDR,
    input  logic [7:0]           S_AXI_ARLEN,
    input  logic [2:0]           S_AXI_ARSIZE,
    input  logic [1:0]           S_AXI_ARBURST,
    output logic                 S_AXI_ARREADY,
    output logic                 S_AXI_RVALID,
    output logic [DATA_WD-1:0]   S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RLAST,
    input  logic                 S_AXI_RREADY,
    input  logic                 S_AXI_AWVALID,
    input  logic [ADDR_WD-1:0]   S_AXI_AWADDR,
    input  logic [7:0]           S_AXI_AWLEN,
    input  logic [2:0]           S_AXI_AWSIZE,
    input  logic [1:0]           S_AXI_AWBURST,
    output logic                 S_AXI_AWREADY,
    input  logic                 S_AXI_WVALID,
    input  logic [DATA_WD-1:0]   S_AXI_WDATA,
    input  logic [DATA_WD/8-1:0] S_AXI_WSTRB,
    input  logic                 S_AXI_WLAST,
    output logic                 S_AXI_WREADY,
    output logic                 S_AXI_BVALID,
    output logic [1:0]           S_AXI_BRESP,
    input  logic                 S_AXI_BREADY
);

    localparam int STRB_WD  = DATA_WD / 8;
    localparam int BYTE_LSB = $clog2(STRB_WD);
    localparam int IDX_WD   = $clog2(MEM_DEPTH);
    localparam int IDX_HI   = IDX_WD + BYTE_LSB;
`ifdef AXI_MEM_OOR_SLVERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic [IDX_WD-1:0] word_idx(input logic [ADDR_WD-1:0] a);
        return a[IDX_HI-1:BYTE_LSB];
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WD-1:0] a);
        return OOR_EN && (|a[ADDR_WD-1:IDX_HI]);
    endfunction

    function automatic logic len_too_long(input logic [7:0] len);
        return (int'(len) + 1) > MAX_BURST_LEN;
    endfunction

    logic [DATA_WD-1:0] mem [MEM_DEPTH];
    logic [DATA_WD-1:0] mem_rdata_q;

    // ---------------- read path ----------------
    r_state_t           r_state_q, r_state_d;
    logic [ADDR_WD-1:0] r_addr_q, r_addr_d, r_next_addr, rd_load_addr;
    logic [7:0]         r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]         r_size_q, r_size_d;
    logic [1:0]         r_burst_q, r_burst_d;
    logic               r_err_q, r_err_d, r_oor_q, r_oor_d;
    logic               arready_q, arready_d, rvalid_q, rvalid_d;
    logic               ar_hs, r_hs, r_last, rd_load;

    axi_mem_addr_gen #(.ADDR_WD(ADDR_WD)) u_rd_addr_gen (
        .addr      (r_addr_q),
        .size      (r_size_q),
        .len       (r_len_q),
        .burst     (r_burst_q),
        .next_addr (r_next_addr)
    );

    assign ar_hs  = S_AXI_ARVALID & arready_q;
    assign r_hs   = rvalid_q & S_AXI_RREADY;
    assign r_last = (r_cnt_q == r_len_q);

    always_comb begin
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_size_d     = r_size_q;
        r_burst_d    = r_burst_q;
        r_cnt_d      = r_cnt_q;
        r_err_d      = r_err_q;
        rvalid_d     = rvalid_q;
        rd_load      = 1'b0;
        rd_load_addr = r_next_addr;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d    = R_DATA;
                    r_addr_d     = S_AXI_ARADDR;
                    r_len_d      = S_AXI_ARLEN;
                    r_size_d     = S_AXI_ARSIZE;
                    r_burst_d    = S_AXI_ARBURST;
                    r_cnt_d      = 8'd0;
                    r_err_d      = len_too_long(S_AXI_ARLEN);
                    rvalid_d     = 1'b1;
                    rd_load      = 1'b1;
                    rd_load_addr = S_AXI_ARADDR;
                end
            end
            default: begin
                if (r_hs) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                    end else begin
                        r_addr_d = r_next_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rd_load  = 1'b1;
                    end
                end
            end
        endcase
        r_oor_d   = rd_load ? out_of_range(rd_load_addr) : r_oor_q;
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            r_oor_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            r_oor_q   <= r_oor_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Registered RAM read; a same-edge write to this word lands after the read (old data).
    always_ff @(posedge clk) begin
        if (rd_load) begin
            mem_rdata_q <= mem[word_idx(rd_load_addr)];
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = (rvalid_q && !r_oor_q) ? mem_rdata_q : '0;
    assign S_AXI_RRESP   = (rvalid_q && (r_err_q || r_oor_q)) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RLAST   = rvalid_q & r_last;

    // ---------------- write path ----------------
    w_state_t           w_state_q, w_state_d;
    logic [ADDR_WD-1:0] w_addr_q, w_addr_d, w_next_addr;
    logic [7:0]         w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]         w_size_q, w_size_d;
    logic [1:0]         w_burst_q, w_burst_d;
    logic               w_err_q, w_err_d, awready_q, awready_d;
    logic               aw_hs, w_hs, w_beat_oor, mem_we;
    logic               unused_wlast;

    // Burst length comes from the beat counter, so WLAST is only observed.
    assign unused_wlast = S_AXI_WLAST;

    axi_mem_addr_gen #(.ADDR_WD(ADDR_WD)) u_wr_addr_gen (
        .addr      (w_addr_q),
        .size      (w_size_q),
        .len       (w_len_q),
        .burst     (w_burst_q),
        .next_addr (w_next_addr)
    );

    assign aw_hs      = S_AXI_AWVALID & awready_q;
    assign w_hs       = S_AXI_WVALID & (w_state_q == W_DATA);
    assign w_beat_oor = out_of_range(w_addr_q);
    assign mem_we     = w_hs & ~w_beat_oor;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    w_addr_d  = S_AXI_AWADDR;
                    w_len_d   = S_AXI_AWLEN;
                    w_size_d  = S_AXI_AWSIZE;
                    w_burst_d = S_AXI_AWBURST;
                    w_cnt_d   = 8'd0;
                    w_err_d   = len_too_long(S_AXI_AWLEN);
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_err_d = w_err_q | w_beat_oor;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = w_next_addr;
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_WD; b++) begin
            if (mem_we && S_AXI_WSTRB[b]) begin
                mem[word_idx(w_addr_q)][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = ((w_state_q == W_RESP) && w_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected R beats / B responses,
// a negedge monitor pops and compares them and checks hold-under-backpressure.
module tb_axi_mem_slave;
    import axi4_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARREADY(arready),
        .S_AXI_RVALID(rvalid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RREADY(rready),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWREADY(awready),
        .S_AXI_WVALID(wvalid), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WREADY(wready),
        .S_AXI_BVALID(bvalid), .S_AXI_BRESP(bresp), .S_AXI_BREADY(bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      r_exp[$];
    logic [1:0]  b_exp[$];
    logic [31:0] wq[$];
    logic [31:0] eq[$];
    int          total = 0;
    int          bad   = 0;
    int          r_beats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that completed the handshake.
    task automatic wait_hs(input int sel, input string name);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            case (sel)
                0:       got = awready;
                1:       got = wready;
                default: got = arready;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_b_done();
        int n = 0;
        while (b_exp.size() != 0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (b_exp.size() != 0) begin
            timeout_fail("b_done");
            b_exp.delete();
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input logic [1:0] resp, input bit wait_b);
        b_exp.push_back(resp);
        awaddr  = addr;
        awlen   = len;
        awsize  = 3'd2;
        awburst = burst;
        awvalid = 1'b1;
        wait_hs(0, "aw_hs");
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wq[i];
            wstrb  = strb;
            wlast  = (i == int'(len));
            wait_hs(1, "w_hs");
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        @(posedge clk);
        #1;
        if (wait_b) wait_b_done();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] resp);
        rbeat_t e;
        int n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = eq[i];
            e.resp = resp;
            e.last = (i == int'(len));
            r_exp.push_back(e);
        end
        araddr  = addr;
        arlen   = len;
        arsize  = 3'd2;
        arburst = burst;
        arvalid = 1'b1;
        wait_hs(2, "ar_hs");
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        @(posedge clk);
        #1;
        while (r_exp.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (r_exp.size() != 0) begin
            timeout_fail("r_done");
            r_exp.delete();
        end
    endtask

    // Monitor: compares every handshaken beat and checks outputs hold while stalled.
    rbeat_t      mon_e;
    logic [1:0]  mon_b;
    bit          hold_r = 1'b0;
    bit          hold_b = 1'b0;
    logic [31:0] hold_rdata;
    logic        hold_rlast;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_r) begin
                chk("rvalid_held", 64'(rvalid), 64'd1);
                chk("rdata_stable", 64'(rdata), 64'(hold_rdata));
                chk("rlast_stable", 64'(rlast), 64'(hold_rlast));
            end
            hold_r = 1'b0;
            if (rvalid && rready) begin
                r_beats++;
                if (r_exp.size() == 0) begin
                    timeout_fail("r_unexpected_beat");
                end else begin
                    mon_e = r_exp.pop_front();
                    chk("rdata", 64'(rdata), 64'(mon_e.data));
                    chk("rresp", 64'(rresp), 64'(mon_e.resp));
                    chk("rlast", 64'(rlast), 64'(mon_e.last));
                end
                $display("R beat data=%08h resp=%0d last=%0d", rdata, rresp, rlast);
            end else if (rvalid) begin
                hold_r     = 1'b1;
                hold_rdata = rdata;
                hold_rlast = rlast;
            end

            if (hold_b) chk("bvalid_held", 64'(bvalid), 64'd1);
            hold_b = 1'b0;
            if (bvalid) begin
                chk("awready_low_in_resp", 64'(awready), 64'd0);
                if (bready) begin
                    if (b_exp.size() == 0) begin
                        timeout_fail("b_unexpected");
                    end else begin
                        mon_b = b_exp.pop_front();
                        chk("bresp", 64'(bresp), 64'(mon_b));
                    end
                    $display("B resp=%0d", bresp);
                end else begin
                    hold_b = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1'b1;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arready_before_edge", 64'(arready), 64'd0);
        @(negedge clk);
        chk("arready_after_rst", 64'(arready), 64'd1);
        chk("awready_after_rst", 64'(awready), 64'd1);
        @(posedge clk);
        #1;

        // INCR write then read back
        wq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        axi_write(32'h100, 8'd3, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
        eq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        axi_read(32'h100, 8'd3, BURST_INCR, RESP_OKAY);

        // R backpressure: stall 5 cycles after the 2nd beat
        r_beats = 0;
        fork
            axi_read(32'h100, 8'd3, BURST_INCR, RESP_OKAY);
            begin
                n = 0;
                while (r_beats < 2 && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                rready = 1'b0;
                repeat (5) @(posedge clk);
                #1 rready = 1'b1;
            end
        join

        // B backpressure: BREADY low for 3 cycles
        bready = 1'b0;
        wq = {32'h55};
        axi_write(32'h200, 8'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b0);
        repeat (2) @(posedge clk);
        #1 bready = 1'b1;
        wait_b_done();

        // WSTRB partial write
        wq = {32'h11223344};
        axi_write(32'h40, 8'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
        wq = {32'hAABBCCDD};
        axi_write(32'h40, 8'd0, BURST_INCR, 4'h5, RESP_OKAY, 1'b1);
        eq = {32'h11BB33DD};
        axi_read(32'h40, 8'd0, BURST_INCR, RESP_OKAY);

        // WRAP read over 0x30..0x3C starting at 0x38
        wq = {32'hC0, 32'hC1, 32'hC2, 32'hC3};
        axi_write(32'h30, 8'd3, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
        eq = {32'hC2, 32'hC3, 32'hC0, 32'hC1};
        axi_read(32'h38, 8'd3, BURST_WRAP, RESP_OKAY);

        // FIXED read and FIXED write
        wq = {32'hF0};
        axi_write(32'h20, 8'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
        eq = {32'hF0, 32'hF0, 32'hF0, 32'hF0};
        axi_read(32'h20, 8'd3, BURST_FIXED, RESP_OKAY);
        wq = {32'h1, 32'h2, 32'h3, 32'h4};
        axi_write(32'h24, 8'd3, BURST_FIXED, 4'hF, RESP_OKAY, 1'b1);
        eq = {32'h4};
        axi_read(32'h24, 8'd0, BURST_INCR, RESP_OKAY);

        // Reserved burst type behaves as INCR
        eq = {32'hA0, 32'hA1};
        axi_read(32'h100, 8'd1, BURST_RSVD, RESP_OKAY);

        // Over-long bursts: served, but SLVERR
        wq.delete();
        eq.delete();
        for (int i = 0; i < 17; i++) begin
            wq.push_back(32'h1000 + i);
            eq.push_back(32'h1000 + i);
        end
        axi_write(32'h300, 8'd16, BURST_INCR, 4'hF, RESP_SLVERR, 1'b1);
        axi_read(32'h300, 8'd16, BURST_INCR, RESP_SLVERR);

        // Addresses above the array
        wq = {32'hDEAD0000, 32'h66};
        axi_write(32'h0, 8'd1, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
`ifdef AXI_MEM_OOR_SLVERR_EN
        eq = {32'h0};
        axi_read(32'h1000, 8'd0, BURST_INCR, RESP_SLVERR);
        wq = {32'h77};
        axi_write(32'h1004, 8'd0, BURST_INCR, 4'hF, RESP_SLVERR, 1'b1);
        eq = {32'h66};
        axi_read(32'h4, 8'd0, BURST_INCR, RESP_OKAY);
`else
        eq = {32'hDEAD0000};
        axi_read(32'h1000, 8'd0, BURST_INCR, RESP_OKAY);
        wq = {32'h77};
        axi_write(32'h1004, 8'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b1);
        eq = {32'h77};
        axi_read(32'h4, 8'd0, BURST_INCR, RESP_OKAY);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
